gem_fiber_in: RTL and testbench

Receive-side deframer for the GEM trigger fiber link, in the TRG_CLK80 domain after the GTX receiver's 8b10b decoder. It consumes 32-bit decoded words carrying 56-bit GEM cluster frames as two words per 40 MHz bunch:

- **Word A:** data[55:24], ISK 4'b0000.
- **Word B:** {data[23:0], frame-separator K-code}, ISK 4'b0001.

The block finds frame phase, reassembles and qualifies frames, and reports link idle/reset, lock and overflow status to downstream trigger logic.

---
 rtl/gem_fiber_pkg.sv | 26 ++
 rtl/gem_rx_word_class.sv | 23 ++
 rtl/gem_fiber_in.sv | 150 +++++++++++++++
 tb/tb_gem_fiber_in.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gem_fiber_pkg.sv
// Shared constants and state type for the GEM trigger fiber receive deframer.
// Two 32-bit words per 56-bit frame: word A = data[55:24], word B = {data[23:0], separator K-code}.
package gem_fiber_pkg;

  localparam logic [7:0]  K_BC      = 8'hBC;
  localparam logic [7:0]  K_F7      = 8'hF7;
  localparam logic [7:0]  K_FB      = 8'hFB;
  localparam logic [7:0]  K_FD      = 8'hFD;
  localparam logic [7:0]  K_FC      = 8'hFC;

  localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;
  localparam logic [3:0]  IDLE_ISK  = 4'b0101;
  localparam logic [3:0]  ISK_A     = 4'b0000;
  localparam logic [3:0]  ISK_B     = 4'b0001;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic is_frame_sep(input logic [7:0] b);
    return (b == K_BC) || (b == K_F7) || (b == K_FB) || (b == K_FD) || (b == K_FC);
  endfunction

endpackage

// File: rtl/gem_rx_word_class.sv
// Combinational classifier of one decoded receive word (idle / good A / good B).
// Zero latency, no state; flow control is the caller's concern.
module gem_rx_word_class
  import gem_fiber_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [3:0]  i_isk,
  input  logic [3:0]  i_err,
  output logic        o_is_idle,
  output logic        o_good_a,
  output logic        o_good_b,
  output logic        o_sep_valid
);

  logic w_no_err;

  assign w_no_err    = (i_err == 4'b0000);
  assign o_sep_valid = is_frame_sep(i_data[7:0]);
  assign o_is_idle   = w_no_err && (i_data == IDLE_WORD) && (i_isk == IDLE_ISK);
  assign o_good_a    = w_no_err && (i_isk == ISK_A);
  assign o_good_b    = w_no_err && (i_isk == ISK_B) && o_sep_valid;

endmodule

// File: rtl/gem_fiber_in.sv
// GEM fiber deframer: phase hunt, lock qualification, frame reassembly; GEM_VALID 1 cycle after word B, no backpressure.
// Optional bad-frame counter ERR_CNT is built only when GEM_FIBER_IN_ERRCNT_EN is defined.
module gem_fiber_in
  import gem_fiber_pkg::*;
#(
  parameter int LOCK_FRAMES = 4,
  parameter int LOSS_FRAMES = 2
) (
  input  logic        TRG_CLK80,
  input  logic        TRG_RST_N,
  input  logic [31:0] RX_DATA,
  input  logic [3:0]  RX_ISK,
  input  logic [3:0]  RX_ERR,
  output logic [55:0] GEM_DATA,
  output logic        GEM_VALID,
  output logic        GEM_OVERFLOW,
  output logic [7:0]  FRM_SEP,
  output logic        RX_SYNC,
`ifdef GEM_FIBER_IN_ERRCNT_EN
  output logic        LINK_IDLE,
  output logic [15:0] ERR_CNT
`else
  output logic        LINK_IDLE
`endif
);

  localparam logic [3:0] LP_LOCK = 4'(LOCK_FRAMES);
  localparam logic [3:0] LP_LOSS = 4'(LOSS_FRAMES);

  state_t      r_state;
  logic        r_expect_b;
  logic        r_a_ok;
  logic [31:0] r_hold;
  logic [3:0]  r_good_cnt;
  logic [3:0]  r_bad_cnt;

  logic        w_idle, w_good_a, w_good_b, w_sep_valid, w_frame_ok;
  logic [3:0]  w_good_next, w_bad_next;

  gem_rx_word_class u_class (
    .i_data      (RX_DATA),
    .i_isk       (RX_ISK),
    .i_err       (RX_ERR),
    .o_is_idle   (w_idle),
    .o_good_a    (w_good_a),
    .o_good_b    (w_good_b),
    .o_sep_valid (w_sep_valid)
  );

  assign w_frame_ok  = r_a_ok && w_good_b && w_sep_valid;
  assign w_good_next = (r_good_cnt == 4'hF) ? 4'hF : r_good_cnt + 4'd1;
  assign w_bad_next  = (r_bad_cnt  == 4'hF) ? 4'hF : r_bad_cnt  + 4'd1;

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      r_state      <= HUNT;
      r_expect_b   <= 1'b0;
      r_a_ok       <= 1'b0;
      r_hold       <= '0;
      r_good_cnt   <= '0;
      r_bad_cnt    <= '0;
      GEM_DATA     <= '0;
      GEM_VALID    <= 1'b0;
      GEM_OVERFLOW <= 1'b0;
      FRM_SEP      <= K_BC;
      RX_SYNC      <= 1'b0;
      LINK_IDLE    <= 1'b0;
    end else begin
      GEM_VALID <= 1'b0;
      LINK_IDLE <= w_idle;
      // Idle overrides everything: the far end has stopped framing.
      if (w_idle) begin
        r_state    <= HUNT;
        r_good_cnt <= '0;
        r_bad_cnt  <= '0;
        RX_SYNC    <= 1'b0;
      end else begin
        case (r_state)
          HUNT: begin
            if (w_good_b) begin
              r_state    <= CHECK;
              r_expect_b <= 1'b0;
              r_good_cnt <= '0;
            end
          end
          CHECK: begin
            if (!r_expect_b) begin
              if (w_good_a) begin
                r_hold     <= RX_DATA;
                r_expect_b <= 1'b1;
              end else begin
                r_state <= HUNT;
              end
            end else if (w_good_b) begin
              r_expect_b <= 1'b0;
              r_good_cnt <= w_good_next;
              if (w_good_next >= LP_LOCK) begin
                r_state   <= LOCKED;
                r_bad_cnt <= '0;
                RX_SYNC   <= 1'b1;
              end
            end else begin
              r_state <= HUNT;
            end
          end
          LOCKED: begin
            // Phase free-runs here; data never re-derives it.
            r_expect_b <= !r_expect_b;
            if (!r_expect_b) begin
              r_hold <= RX_DATA;
              r_a_ok <= w_good_a;
            end else if (w_frame_ok) begin
              GEM_VALID    <= 1'b1;
              GEM_DATA     <= {r_hold, RX_DATA[31:8]};
              FRM_SEP      <= RX_DATA[7:0];
              GEM_OVERFLOW <= (RX_DATA[7:0] == K_FC);
              r_bad_cnt    <= '0;
            end else begin
              r_bad_cnt <= w_bad_next;
              if (w_bad_next >= LP_LOSS) begin
                r_state    <= HUNT;
                r_good_cnt <= '0;
                r_bad_cnt  <= '0;
                RX_SYNC    <= 1'b0;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

`ifdef GEM_FIBER_IN_ERRCNT_EN
  logic w_err_evt;

  assign w_err_evt = !w_idle &&
                     (((r_state == CHECK) && (r_expect_b ? !w_good_b : !w_good_a)) ||
                      ((r_state == LOCKED) && r_expect_b && !w_frame_ok));

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      ERR_CNT <= '0;
    end else if (w_err_evt && (ERR_CNT != 16'hFFFF)) begin
      ERR_CNT <= ERR_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gem_fiber_in.sv
// Directed bench for gem_fiber_in: stimulus pushes expected frames, a monitor pops on every GEM_VALID.
// Builds with or without GEM_FIBER_IN_ERRCNT_EN.
module tb_gem_fiber_in;
  import gem_fiber_pkg::*;

  typedef struct packed {
    logic [55:0] d;
    logic [7:0]  sep;
    logic        ovf;
  } exp_t;

  localparam logic [55:0] D1 = 56'h0123456789ABCD;
  localparam logic [55:0] D2 = 56'hFEDCBA98765432;
  localparam logic [55:0] D3 = 56'h0F1E2D3C4B5A69;
  localparam logic [55:0] D4 = 56'h13579BDF02468A;

  logic        clk;
  logic        rst_n;
  logic [31:0] RX_DATA;
  logic [3:0]  RX_ISK;
  logic [3:0]  RX_ERR;
  logic [55:0] GEM_DATA;
  logic        GEM_VALID;
  logic        GEM_OVERFLOW;
  logic [7:0]  FRM_SEP;
  logic        RX_SYNC;
  logic        LINK_IDLE;
`ifdef GEM_FIBER_IN_ERRCNT_EN
  logic [15:0] ERR_CNT;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  logic prev_valid = 1'b0;

  gem_fiber_in #(.LOCK_FRAMES(4), .LOSS_FRAMES(2)) dut (
    .TRG_CLK80    (clk),
    .TRG_RST_N    (rst_n),
    .RX_DATA      (RX_DATA),
    .RX_ISK       (RX_ISK),
    .RX_ERR       (RX_ERR),
    .GEM_DATA     (GEM_DATA),
    .GEM_VALID    (GEM_VALID),
    .GEM_OVERFLOW (GEM_OVERFLOW),
    .FRM_SEP      (FRM_SEP),
    .RX_SYNC      (RX_SYNC),
`ifdef GEM_FIBER_IN_ERRCNT_EN
    .LINK_IDLE    (LINK_IDLE),
    .ERR_CNT      (ERR_CNT)
`else
    .LINK_IDLE    (LINK_IDLE)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One word per cycle: drive on the falling edge, return just after the sampling edge.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e);
    @(negedge clk);
    RX_DATA = d;
    RX_ISK  = k;
    RX_ERR  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [55:0] d, input logic [7:0] sep,
                            input logic [3:0] ea, input logic [3:0] eb, input bit exp_v);
    exp_t e;
    if (exp_v) begin
      e.d   = d;
      e.sep = sep;
      e.ovf = (sep == 8'hFC);
      sb_q.push_back(e);
    end
    send(d[55:24], ISK_A, ea);
    send({d[23:0], sep}, ISK_B, eb);
  endtask

  task automatic send_idle();
    send(IDLE_WORD, IDLE_ISK, 4'b0000);
  endtask

  // From HUNT: first frame sets phase, next four qualify, then one delivered frame.
  task automatic relock(input logic [55:0] d, input string name);
    for (int i = 0; i < 5; i++) send_frame(d, K_BC, 4'b0, 4'b0, 1'b0);
    chk({name, "_sync"}, {63'd0, RX_SYNC}, 64'd1);
    send_frame(d, K_BC, 4'b0, 4'b0, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_data"}, {8'd0, GEM_DATA}, 64'd0);
    chk({name, "_valid"}, {63'd0, GEM_VALID}, 64'd0);
    chk({name, "_ovf"}, {63'd0, GEM_OVERFLOW}, 64'd0);
    chk({name, "_sep"}, {56'd0, FRM_SEP}, 64'hBC);
    chk({name, "_sync"}, {63'd0, RX_SYNC}, 64'd0);
    chk({name, "_idle"}, {63'd0, LINK_IDLE}, 64'd0);
`ifdef GEM_FIBER_IN_ERRCNT_EN
    chk({name, "_errcnt"}, {48'd0, ERR_CNT}, 64'd0);
`endif
  endtask

  // Scoreboard monitor
  always begin
    @(posedge clk);
    #1;
    if (GEM_VALID) begin
      chk("valid_spacing", {63'd0, prev_valid}, 64'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_data", {8'd0, GEM_DATA}, {8'd0, e.d});
        chk("sb_sep", {56'd0, FRM_SEP}, {56'd0, e.sep});
        chk("sb_ovf", {63'd0, GEM_OVERFLOW}, {63'd0, e.ovf});
      end
    end
    prev_valid = GEM_VALID;
  end

  initial begin
    rst_n   = 1'b0;
    RX_DATA = '0;
    RX_ISK  = '0;
    RX_ERR  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Lock from idle
    send_idle();
    chk("idle_first", {63'd0, LINK_IDLE}, 64'd1);
    repeat (9) send_idle();
    chk("idle_last", {63'd0, LINK_IDLE}, 64'd1);
    chk("idle_nosync", {63'd0, RX_SYNC}, 64'd0);
    for (int i = 1; i <= 8; i++) begin
      send_frame(D1, K_BC, 4'b0, 4'b0, i >= 6);
      chk($sformatf("lock_sync_f%0d", i), {63'd0, RX_SYNC}, {63'd0, i >= 5});
    end
    chk("idle_cleared", {63'd0, LINK_IDLE}, 64'd0);

    // Overflow separator
    send_frame(D2, K_FC, 4'b0, 4'b0, 1'b1);
    chk("ovf_sep", {56'd0, FRM_SEP}, 64'hFC);
    send_frame(D1, K_BC, 4'b0, 4'b0, 1'b1);
    chk("ovf_cleared", {63'd0, GEM_OVERFLOW}, 64'd0);

    // Error tolerance
    send_frame(D3, K_BC, 4'b0010, 4'b0, 1'b0);
    chk("err1_sync", {63'd0, RX_SYNC}, 64'd1);
    chk("err1_hold", {8'd0, GEM_DATA}, {8'd0, D1});
`ifdef GEM_FIBER_IN_ERRCNT_EN
    chk("err1_errcnt", {48'd0, ERR_CNT}, 64'd1);
`endif
    send_frame(D1, K_BC, 4'b0, 4'b0, 1'b1);
    send_frame(D3, K_BC, 4'b0010, 4'b0, 1'b0);
    chk("err2a_sync", {63'd0, RX_SYNC}, 64'd1);
    send_frame(D3, K_BC, 4'b0, 4'b0001, 1'b0);
    chk("err2b_sync", {63'd0, RX_SYNC}, 64'd0);
`ifdef GEM_FIBER_IN_ERRCNT_EN
    chk("err2_errcnt", {48'd0, ERR_CNT}, 64'd3);
`endif
    relock(D1, "relock1");

    // Phase slip: word A of D3 is lost
    send({D3[23:0], K_BC}, ISK_B, 4'b0);
    send(D1[55:24], ISK_A, 4'b0);
    chk("slip1_sync", {63'd0, RX_SYNC}, 64'd1);
    send({D1[23:0], K_BC}, ISK_B, 4'b0);
    send(D1[55:24], ISK_A, 4'b0);
    chk("slip2_sync", {63'd0, RX_SYNC}, 64'd0);
    send({D1[23:0], K_BC}, ISK_B, 4'b0);
    for (int i = 0; i < 4; i++) send_frame(D4, K_BC, 4'b0, 4'b0, 1'b0);
    chk("slip_relock_sync", {63'd0, RX_SYNC}, 64'd1);
`ifdef GEM_FIBER_IN_ERRCNT_EN
    chk("slip_errcnt", {48'd0, ERR_CNT}, 64'd5);
`endif
    send_frame(D4, K_BC, 4'b0, 4'b0, 1'b1);

    // Idle while locked
    send_idle();
    chk("lidle_sync", {63'd0, RX_SYNC}, 64'd0);
    chk("lidle_idle", {63'd0, LINK_IDLE}, 64'd1);
    chk("lidle_valid", {63'd0, GEM_VALID}, 64'd0);
`ifdef GEM_FIBER_IN_ERRCNT_EN
    chk("lidle_errcnt", {48'd0, ERR_CNT}, 64'd5);
`endif
    relock(D2, "relock2");
    chk("relock2_idle", {63'd0, LINK_IDLE}, 64'd0);

    // Async reset between word A and word B
    send(D1[55:24], ISK_A, 4'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    #1;
    rst_n = 1'b1;
    send({D1[23:0], K_BC}, ISK_B, 4'b0);
    chk("arst_b_valid", {63'd0, GEM_VALID}, 64'd0);
    chk("arst_b_sync", {63'd0, RX_SYNC}, 64'd0);
    send_idle();
    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
